if_id_buf: RTL and testbench

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf_pkg.sv | 16 +
 rtl/if_id_buf_sat_cnt16.sv | 18 +
 rtl/if_id_buf.sv | 124 ++++++++++++
 tb/tb_if_id_buf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared types and constants for the IF/ID instruction buffer.
package if_id_buf_pkg;

  localparam int TRD_W = 3;
  localparam int XLEN  = 32;

  // One buffered fetch: instruction word, its PC, its thread and a live bit
  // that a thread flush can clear while the slot stays allocated.
  typedef struct packed {
    logic [XLEN-1:0]  ins;
    logic [XLEN-1:0]  pc;
    logic [TRD_W-1:0] trd;
    logic             vld;
  } entry_t;

endpackage

// File: rtl/if_id_buf_sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  // Count qualifying cycles, holding at the all-ones ceiling.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID instruction buffer: circular FIFO between fetch and decode with
// global and per-thread flush. Define IFID_PERF_EN to add the saturating
// bubble/stall/flush performance counters and their output ports.
import if_id_buf_pkg::*;

module if_id_buf #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_vld,
  input  logic [XLEN-1:0]  if_ins,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [TRD_W-1:0] if_trd,
  input  logic             if_miss,
  output logic             if_rdy,
  output logic             id_vld,
  output logic [XLEN-1:0]  id_ins,
  output logic [XLEN-1:0]  id_pc,
  output logic [TRD_W-1:0] id_trd,
  input  logic             id_rdy,
  input  logic             flushID,
  input  logic             flush_trd_en,
  input  logic [TRD_W-1:0] flush_trd,
  output logic [$clog2(DEPTH):0] occ
`ifdef IFID_PERF_EN
  ,
  output logic [15:0]      perf_bubble,
  output logic [15:0]      perf_stall,
  output logic [15:0]      perf_flush
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  entry_t          slots [DEPTH];
  entry_t          head_e;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [OW-1:0]   occ_q;
  logic [OW-1:0]   occ_nxt;
  logic            rdy_q;
  logic            push;
  logic            pop;
  logic            kill_in;

  assign head_e = slots[head];
  assign occ    = occ_q;
  assign if_rdy = rdy_q;
  assign id_vld = (occ_q != '0) && head_e.vld;
  assign id_ins = head_e.ins;
  assign id_pc  = head_e.pc;
  assign id_trd = head_e.trd;

  // Enqueue/dequeue decisions and next occupancy. An allocated head whose
  // live bit was cleared by a thread flush is popped without a handshake.
  always_comb begin
    kill_in = flush_trd_en && (if_trd == flush_trd);
    push    = if_vld && !if_miss && rdy_q && !flushID && !kill_in;
    pop     = (occ_q != '0) && (!head_e.vld || id_rdy);
    occ_nxt = occ_q;
    if (flushID) begin
      occ_nxt = '0;
    end else begin
      occ_nxt = occ_q + OW'(push) - OW'(pop);
    end
  end

  // Pointer, occupancy and slot storage update. if_rdy is registered from
  // the next occupancy so it never depends combinationally on id_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
      rdy_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      occ_q <= occ_nxt;
      rdy_q <= (occ_nxt < OW'(DEPTH));
      if (flushID) begin
        head <= '0;
        tail <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          slots[i].vld <= 1'b0;
        end
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (flush_trd_en && (slots[i].trd == flush_trd)) begin
            slots[i].vld <= 1'b0;
          end
        end
        if (push) begin
          slots[tail] <= '{ins: if_ins, pc: if_pc, trd: if_trd, vld: 1'b1};
          tail        <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end
      end
    end
  end

`ifdef IFID_PERF_EN
  logic bubble_ev;
  logic stall_ev;
  logic flush_ev;

  // Classify this cycle for the performance counters.
  always_comb begin
    bubble_ev = id_rdy && !id_vld;
    stall_ev  = if_vld && !if_miss && !rdy_q;
    flush_ev  = flushID || flush_trd_en;
  end

  sat_cnt16 u_bubble (.clk(clk), .rst(rst), .inc(bubble_ev), .cnt(perf_bubble));
  sat_cnt16 u_stall  (.clk(clk), .rst(rst), .inc(stall_ev),  .cnt(perf_stall));
  sat_cnt16 u_flush  (.clk(clk), .rst(rst), .inc(flush_ev),  .cnt(perf_flush));
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Directed self-checking bench for if_id_buf (DEPTH=2). The perf counter
// scenario is compiled only when IFID_PERF_EN is defined.
module tb_if_id_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_vld;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [2:0]  if_trd;
  logic        if_miss;
  logic        if_rdy;
  logic        id_vld;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic [2:0]  id_trd;
  logic        id_rdy;
  logic        flushID;
  logic        flush_trd_en;
  logic [2:0]  flush_trd;
  logic [1:0]  occ;
`ifdef IFID_PERF_EN
  logic [15:0] perf_bubble;
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  int errors = 0;
  int checks = 0;

  if_id_buf #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .if_vld(if_vld), .if_ins(if_ins), .if_pc(if_pc), .if_trd(if_trd),
    .if_miss(if_miss), .if_rdy(if_rdy),
    .id_vld(id_vld), .id_ins(id_ins), .id_pc(id_pc), .id_trd(id_trd),
    .id_rdy(id_rdy), .flushID(flushID), .flush_trd_en(flush_trd_en),
    .flush_trd(flush_trd), .occ(occ)
`ifdef IFID_PERF_EN
    , .perf_bubble(perf_bubble), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_vld = 1'b0; if_ins = '0; if_pc = '0; if_trd = '0; if_miss = 1'b0;
    id_rdy = 1'b0; flushID = 1'b0; flush_trd_en = 1'b0; flush_trd = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [2:0] trd);
    if_vld = 1'b1; if_pc = pc; if_ins = pc ^ 32'hA5A5_0000; if_trd = trd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    checks++; if (if_rdy !== 1'b0) begin errors++; $display("FAIL rst_if_rdy: got %b expected 0", if_rdy); end
    checks++; if (id_vld !== 1'b0) begin errors++; $display("FAIL rst_id_vld: got %b expected 0", id_vld); end
    checks++; if (id_pc !== 32'h0 || id_ins !== 32'h0 || id_trd !== 3'd0) begin
      errors++; $display("FAIL rst_id_data: got pc=%h ins=%h trd=%0d expected zeros", id_pc, id_ins, id_trd); end
    rst = 1'b0;
    step();
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL rel_if_rdy: got %b expected 1", if_rdy); end
    checks++; if (id_vld !== 1'b0) begin errors++; $display("FAIL rel_id_vld: got %b expected 0", id_vld); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rel_occ: got %0d expected 0", occ); end
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    fetch(32'h100, 3'd2); step();
    checks++; if (occ !== 2'd1 || id_vld !== 1'b1 || id_pc !== 32'h100) begin
      errors++; $display("FAIL fill_1: got occ=%0d vld=%b pc=%h expected 1 1 00000100", occ, id_vld, id_pc); end
    checks++; if (id_ins !== 32'hA5A5_0100 || id_trd !== 3'd2) begin
      errors++; $display("FAIL fill_1_data: got ins=%h trd=%0d expected a5a50100 2", id_ins, id_trd); end
    fetch(32'h104, 3'd2); step();
    checks++; if (occ !== 2'd2 || if_rdy !== 1'b0) begin
      errors++; $display("FAIL fill_full: got occ=%0d if_rdy=%b expected 2 0", occ, if_rdy); end
    fetch(32'h108, 3'd2); step();
    checks++; if (occ !== 2'd2 || id_pc !== 32'h100) begin
      errors++; $display("FAIL fill_reject: got occ=%0d pc=%h expected 2 00000100", occ, id_pc); end
    if_vld = 1'b0; id_rdy = 1'b1; step();
    checks++; if (occ !== 2'd1 || id_vld !== 1'b1 || id_pc !== 32'h104) begin
      errors++; $display("FAIL drain_1: got occ=%0d vld=%b pc=%h expected 1 1 00000104", occ, id_vld, id_pc); end
    checks++; if (if_rdy !== 1'b1) begin errors++; $display("FAIL drain_rdy: got %b expected 1", if_rdy); end
    step();
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0) begin
      errors++; $display("FAIL drain_2: got occ=%0d vld=%b expected 0 0", occ, id_vld); end
    idle_inputs();
  endtask

  task automatic test_thread_flush();
    idle_inputs();
    fetch(32'h200, 3'd1); step();
    fetch(32'h300, 3'd3); step();
    checks++; if (id_vld !== 1'b1 || id_pc !== 32'h200 || id_trd !== 3'd1) begin
      errors++; $display("FAIL tf_head: got vld=%b pc=%h trd=%0d expected 1 00000200 1", id_vld, id_pc, id_trd); end
    if_vld = 1'b0; flush_trd_en = 1'b1; flush_trd = 3'd1; step();
    flush_trd_en = 1'b0;
    checks++; if (id_vld !== 1'b0 || occ !== 2'd2) begin
      errors++; $display("FAIL tf_bubble: got vld=%b occ=%0d expected 0 2", id_vld, occ); end
    step();
    checks++; if (id_vld !== 1'b1 || id_pc !== 32'h300 || id_trd !== 3'd3 || occ !== 2'd1) begin
      errors++; $display("FAIL tf_next: got vld=%b pc=%h trd=%0d occ=%0d expected 1 00000300 3 1", id_vld, id_pc, id_trd, occ); end
    id_rdy = 1'b1; step();
    id_rdy = 1'b0;
    // same-cycle enqueue of the flushed thread is dropped
    fetch(32'h2F0, 3'd4); flush_trd_en = 1'b1; flush_trd = 3'd4; step();
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0) begin
      errors++; $display("FAIL tf_drop_enq: got occ=%0d vld=%b expected 0 0", occ, id_vld); end
    idle_inputs();
  endtask

  task automatic test_global_flush();
    idle_inputs();
    fetch(32'h500, 3'd0); step();
    fetch(32'h504, 3'd0); step();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL gf_pre: got occ=%0d expected 2", occ); end
    fetch(32'h400, 3'd0); flushID = 1'b1; step();
    idle_inputs();
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0 || if_rdy !== 1'b1) begin
      errors++; $display("FAIL gf_clear: got occ=%0d vld=%b rdy=%b expected 0 0 1", occ, id_vld, if_rdy); end
    step();
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0) begin
      errors++; $display("FAIL gf_absent: got occ=%0d vld=%b expected 0 0", occ, id_vld); end
  endtask

  task automatic test_miss_wrap();
    idle_inputs();
    fetch(32'h666, 3'd5); if_miss = 1'b1; step();
    if_miss = 1'b0;
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0) begin
      errors++; $display("FAIL miss_noop: got occ=%0d vld=%b expected 0 0", occ, id_vld); end
    for (int k = 0; k < 6; k++) begin
      fetch(32'h600 + 32'(4 * k), 3'd6);
      id_rdy = (k > 0);
      step();
      checks++; if (occ !== 2'd1 || id_vld !== 1'b1 || id_pc !== 32'h600 + 32'(4 * k)) begin
        errors++; $display("FAIL wrap_%0d: got occ=%0d vld=%b pc=%h expected 1 1 %h", k, occ, id_vld, id_pc, 32'h600 + 32'(4 * k)); end
    end
    if_vld = 1'b0; id_rdy = 1'b1; step();
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL wrap_drain: got occ=%0d expected 0", occ); end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    fetch(32'h700, 3'd1); step();
    fetch(32'h704, 3'd1); rst = 1'b1; step();
    checks++; if (occ !== 2'd0 || id_vld !== 1'b0 || if_rdy !== 1'b0 || id_pc !== 32'h0) begin
      errors++; $display("FAIL midrst: got occ=%0d vld=%b rdy=%b pc=%h expected 0 0 0 0", occ, id_vld, if_rdy, id_pc); end
    idle_inputs(); rst = 1'b0; step();
    checks++; if (if_rdy !== 1'b1 || occ !== 2'd0) begin
      errors++; $display("FAIL midrst_rel: got rdy=%b occ=%0d expected 1 0", if_rdy, occ); end
  endtask

`ifdef IFID_PERF_EN
  task automatic test_perf_sat();
    idle_inputs();
    fetch(32'h800, 3'd0); step();
    fetch(32'h804, 3'd0); step();
    force dut.u_stall.cnt = 16'hFFFF;
    step();
    release dut.u_stall.cnt;
    step(); step();
    checks++; if (perf_stall !== 16'hFFFF) begin
      errors++; $display("FAIL perf_stall_sat: got %h expected ffff", perf_stall); end
    idle_inputs(); flushID = 1'b1; step();
    idle_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_thread_flush();
    test_global_flush();
    test_miss_wrap();
    test_reset_midop();
`ifdef IFID_PERF_EN
    test_perf_sat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
